data_mem_responder: RTL and testbench

- Multicycle data-memory responder.
- Executes the load/store requests issued by the multicycle control FSM: lw/lh/lb and sw/sh/sb.
- Accepts a request in IDLE, waits a configurable number of cycles, performs a big-endian byte/half/word access to on-chip RAM, then pulses `Done` with the result.
- Sits between the control/datapath and the data RAM; its `MemRead`/`MemWrite` inputs come straight from the control unit.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/data_ram.sv | 29 ++
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the multicycle data-memory responder: access sizes, FSM states
// and the big-endian byte-enable helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAITS, ACCESS, DONE} state_e;

  // Byte 0 (offset 00) lives in bits [31:24], so enable bit 3 is the lowest address.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] mask;
    mask = 4'b0000;
    unique case (size)
      SZ_BYTE: mask = 4'b1000 >> off;
      SZ_HALF: mask = off[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Synchronous single-port word RAM with per-byte write enables and a registered read port.
module data_ram #(
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multicycle big-endian load/store responder in front of data_ram.
// Define MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  localparam int unsigned WordW   = ADDR_W - 2;
  localparam logic [3:0]  WaitCnt = 4'(WAIT);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              uns_q, rd_q, wr_q;
  logic [31:0]       rdata_q;
  logic              err_q, done_q, busy_q;

  logic              accept;
  logic              misalign, illegal;
  logic [1:0]        lane_off;
  logic [3:0]        ram_we;
  logic              ram_re, ram_en;
  logic [WordW-1:0]  ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_val;

  assign accept = (state_q == IDLE) && (MemRead || MemWrite);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = WaitCnt;
          state_d = (WaitCnt == 4'd0) ? ACCESS : WAITS;
        end
      end
      WAITS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ACCESS;
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = ((size_q == SZ_HALF) && addr_q[0]) ||
                    ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    lane_off = addr_q[1:0];
    if (size_q == SZ_HALF) lane_off = {addr_q[1], 1'b0};
    if (size_q == SZ_WORD) lane_off = 2'b00;
  end

  assign illegal = (rd_q && wr_q) || (size_q == SZ_RSVD) || misalign;

  always_comb begin
    unique case (size_q)
      SZ_BYTE: ram_wdata = {4{wdata_q[7:0]}};
      SZ_HALF: ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  // Reset gates the write so an abort during ACCESS leaves memory untouched.
  assign ram_we = (state_q == ACCESS && wr_q && !illegal && !reset) ?
                  lane_mask(size_q, lane_off) : 4'b0000;

  // The read is issued on the edge entering ACCESS so the word is ready for the DONE register.
  assign ram_re   = (state_d == ACCESS) && (state_q != ACCESS);
  assign ram_en   = ram_re || (ram_we != 4'b0000);
  assign ram_addr = (state_q == IDLE) ? Addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];

  data_ram #(
    .AddrW (WordW)
  ) u_data_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    unique case (lane_off)
      2'd0:    sel_byte = ram_rdata[31:24];
      2'd1:    sel_byte = ram_rdata[23:16];
      2'd2:    sel_byte = ram_rdata[15:8];
      default: sel_byte = ram_rdata[7:0];
    endcase
    sel_half = lane_off[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    unique case (size_q)
      SZ_BYTE: load_val = uns_q ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SZ_HALF: load_val = uns_q ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_val = ram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == ACCESS);
      if (accept) begin
        addr_q  <= Addr[ADDR_W-1:0];
        wdata_q <= WriteData;
        size_q  <= Size;
        uns_q   <= Unsigned;
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
      end
      if (state_q == ACCESS) begin
        err_q   <= illegal;
        rdata_q <= (rd_q && !illegal) ? load_val : 32'd0;
      end
    end
  end

  logic unused_addr;
  assign unused_addr = ^Addr[31:ADDR_W];

  assign ReadData = rdata_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed cases plus random traffic against a
// byte-array memory model; a second instance runs with WAIT=0.
module tb_data_mem_responder;

`ifdef MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd2 = 1'b0, wr2 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [1:0]  size = 2'd0;
  logic        uns_i = 1'b0;
  logic [31:0] rdata2, rdata0;
  logic        busy2, done2, err2, busy0, done0, err0;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] last_rd;
  logic        last_err;
  logic [7:0]  mem_b [2][4096];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(12), .WAIT(2)) dut (
    .clk(clk), .reset(reset), .MemRead(rd2), .MemWrite(wr2), .Addr(addr), .WriteData(wdata),
    .Size(size), .Unsigned(uns_i), .ReadData(rdata2), .Busy(busy2), .Done(done2), .Err(err2)
  );

  data_mem_responder #(.ADDR_W(12), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0), .Addr(addr), .WriteData(wdata),
    .Size(size), .Unsigned(uns_i), .ReadData(rdata0), .Busy(busy0), .Done(done0), .Err(err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Big-endian byte-array model: word at a is {b[a], b[a+1], b[a+2], b[a+3]}.
  function automatic void model(input int sel, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [1:0] sz, input logic uns,
                                output logic [31:0] r, output logic e);
    int ba, nb;
    logic [31:0] v;
    ba = int'(a & 32'hFFF);
    e = (rd && wr) || (sz == 2'd3) ||
        (Trap && ((sz == 2'd1 && ba % 2 != 0) || (sz == 2'd2 && ba % 4 != 0)));
    r = 32'd0;
    if (e) return;
    if (sz == 2'd1) ba -= ba % 2;
    if (sz == 2'd2) ba -= ba % 4;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (wr) begin
      for (int i = 0; i < nb; i++) mem_b[sel][ba+i] = wd[8*(nb-1-i) +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v = (v << 8) | {24'd0, mem_b[sel][ba+i]};
      if (nb < 4 && !uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      r = v;
    end
  endfunction

  task automatic set_req(input int sel, input logic rd, input logic wr);
    if (sel == 1) begin rd0 = rd; wr0 = wr; end
    else begin rd2 = rd; wr2 = wr; end
  endtask

  task automatic run_op(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                        input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          w, done_at;
    logic        b, d;
    w = (sel == 1) ? 0 : 2;
    model(sel, rd, wr, a, wd, sz, uns, exp_rd, exp_err);
    @(negedge clk);
    addr = a; wdata = wd; size = sz; uns_i = uns;
    set_req(sel, rd, wr);
    done_at = -1;
    last_rd = 32'hx;
    last_err = 1'bx;
    for (int k = 1; k <= 20 && done_at < 0; k++) begin
      @(negedge clk);
      // Request stays up until Done; the other fields change and must be ignored.
      addr = $urandom; wdata = $urandom; size = 2'($urandom); uns_i = 1'($urandom);
      b = (sel == 1) ? busy0 : busy2;
      d = (sel == 1) ? done0 : done2;
      check({tag, "_busy"}, {31'd0, b}, {31'd0, (k <= w + 2)});
      if (d) begin
        done_at  = k;
        last_rd  = (sel == 1) ? rdata0 : rdata2;
        last_err = (sel == 1) ? err0 : err2;
        set_req(sel, 1'b0, 1'b0);
      end
    end
    set_req(sel, 1'b0, 1'b0);
    check({tag, "_done_cycle"}, 32'(done_at), 32'(w + 2));
    check({tag, "_rdata"}, last_rd, exp_rd);
    check({tag, "_err"}, {31'd0, last_err}, {31'd0, exp_err});
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, (sel == 1) ? busy0 : busy2, (sel == 1) ? done0 : done2}, 32'd0);
    check({tag, "_hold"}, (sel == 1) ? rdata0 : rdata2, exp_rd);
  endtask

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          op;

    repeat (3) @(negedge clk);
    check("rst_rdata", rdata2, 32'd0);
    check("rst_flags", {29'd0, busy2, done2, err2}, 32'd0);
    check("rst0_rdata", rdata0, 32'd0);
    check("rst0_flags", {29'd0, busy0, done0, err0}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) run_op(0, 1'b0, 1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0, "fill");

    run_op(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, "sw10");
    run_op(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, "lw10");
    check("lw10_const", last_rd, 32'hDEADBEEF);
    run_op(0, 1'b0, 1'b1, 32'h13, 32'hAAAA_AA7F, 2'd0, 1'b0, "sb13");
    run_op(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd0, 1'b0, "lb10");
    check("lb10_const", last_rd, 32'hFFFF_FFDE);
    run_op(0, 1'b1, 1'b0, 32'h13, 32'd0, 2'd0, 1'b0, "lb13");
    check("lb13_const", last_rd, 32'h0000_007F);
    run_op(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, "lw10b");
    check("lw10b_const", last_rd, 32'hDEADBE7F);
    run_op(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd1, 1'b0, "lh10");
    check("lh10_const", last_rd, 32'hFFFF_DEAD);
    run_op(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd1, 1'b1, "lhu10");
    check("lhu10_const", last_rd, 32'h0000_DEAD);

    run_op(0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 2'd2, 1'b0, "both");
    check("both_err_const", {31'd0, last_err}, 32'd1);
    run_op(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, "lw10c");
    check("lw10c_const", last_rd, 32'hDEADBE7F);
    run_op(0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd3, 1'b0, "sz11");
    check("sz11_err_const", {31'd0, last_err}, 32'd1);

    run_op(0, 1'b1, 1'b0, 32'h12, 32'd0, 2'd2, 1'b0, "lw12");
`ifdef MISALIGN_TRAP_EN
    check("lw12_err_const", {31'd0, last_err}, 32'd1);
`else
    check("lw12_const", last_rd, 32'hDEADBE7F);
`endif

    // Reset asserted while the store to 0x20 is in ACCESS.
    @(negedge clk);
    addr = 32'h20; wdata = 32'h1; size = 2'd2; uns_i = 1'b0; wr2 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wr2 = 1'b0;
    @(negedge clk);
    check("abort_rdata", rdata2, 32'd0);
    check("abort_flags", {29'd0, busy2, done2, err2}, 32'd0);
    reset = 1'b0;
    run_op(0, 1'b1, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, "lw20");

    run_op(1, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 2'd2, 1'b0, "w0_sw");
    run_op(1, 1'b1, 1'b0, 32'h40, 32'd0, 2'd2, 1'b0, "w0_lw");
    check("w0_lw_const", last_rd, 32'h1234_5678);
    run_op(1, 1'b1, 1'b0, 32'h42, 32'd0, 2'd0, 1'b1, "w0_lbu");
    check("w0_lbu_const", last_rd, 32'h0000_0056);

    for (int i = 0; i < 150; i++) begin
      a  = $urandom & 32'hFFFF_F0FF;
      wd = $urandom;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      op = $urandom_range(0, 9);
      if (op == 0)     run_op(0, 1'b1, 1'b1, a, wd, sz, 1'($urandom), "rnd_both");
      else if (op < 5) run_op(0, 1'b0, 1'b1, a, wd, sz, 1'($urandom), "rnd_st");
      else             run_op(0, 1'b1, 1'b0, a, wd, sz, 1'($urandom), "rnd_ld");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
